// File: rtl/decoder_scan_pkg.sv
// Shared state and mode encodings for the registered one-hot decoder / scan driver.
package decoder_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Operating state is a pure function of the current enable and mode inputs.
  function automatic state_e next_state(input logic en, input logic mode);
    if (!en)
      return ST_IDLE;
    return (mode == MODE_DIRECT) ? ST_DIRECT : ST_SCAN;
  endfunction

endpackage

// File: rtl/decoder_scan_dwell_counter.sv
// Free-running 0..DWELL-1 counter; tick marks the last cycle of each dwell period.
module dwell_counter #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (run)
      count <= (count == LAST) ? '0 : count + 1'b1;
  end

  assign tick = run && !clr && (count == LAST);

endmodule

// File: rtl/decoder_scan.sv
// Registered N-to-2^N one-hot decoder with a direct mode and an auto-walking scan mode.
module decoder_scan
  import decoder_scan_pkg::*;
#(
  parameter int N     = 2,
  parameter int DWELL = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              mode,
  input  logic [N-1:0]      sel,
  input  logic              load,
  output logic [2**N-1:0]   d,
  output logic [N-1:0]      idx,
  output logic              wrap
);

  localparam int W = 2**N;

  state_e       state_p1;
  state_e       state_nxt;
  logic         scan_entry;
  logic         cnt_clr;
  logic         cnt_run;
  logic         tick;
  logic [N-1:0] idx_nxt;
  logic         wrap_nxt;

  function automatic logic [W-1:0] onehot(input logic [N-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  dwell_counter #(.DWELL(DWELL)) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .run   (cnt_run),
    .tick  (tick)
  );

  // A load or a fresh entry into scan restarts the dwell period, so it overrides any expiry.
  always_comb begin
    state_nxt  = next_state(en, mode);
    scan_entry = (state_nxt == ST_SCAN) && (state_p1 != ST_SCAN);
    cnt_clr    = (state_nxt != ST_SCAN) || scan_entry || load;
    cnt_run    = !cnt_clr;
    idx_nxt    = idx;
    wrap_nxt   = 1'b0;
    case (state_nxt)
      ST_DIRECT: idx_nxt = sel;
      ST_SCAN: begin
        if (scan_entry || load)
          idx_nxt = load ? sel : '0;
        else if (tick) begin
          idx_nxt  = idx + 1'b1;
          wrap_nxt = (idx == '1);
        end
      end
      default: ;
    endcase
  end

  // Output stage: d is encoded from the same next index as idx, so the two never skew.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_p1 <= ST_IDLE;
      idx      <= '0;
      d        <= '0;
      wrap     <= 1'b0;
    end else begin
      state_p1 <= state_nxt;
      idx      <= idx_nxt;
      wrap     <= wrap_nxt;
      d        <= (state_nxt == ST_IDLE) ? '0 : onehot(idx_nxt);
    end
  end

endmodule

// File: tb/tb_decoder_scan.sv
// Bench for decoder_scan: two instances (N=2/DWELL=3 and N=3/DWELL=1) against a behavioural model.
module tb_decoder_scan;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       mode;
  logic       load;
  logic [1:0] sel_a;
  logic [2:0] sel_b;
  logic [3:0] d_a;
  logic [1:0] idx_a;
  logic       wrap_a;
  logic [7:0] d_b;
  logic [2:0] idx_b;
  logic       wrap_b;

  int total = 0;
  int bad   = 0;

  decoder_scan #(.N(2), .DWELL(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel_a), .load(load),
    .d(d_a), .idx(idx_a), .wrap(wrap_a)
  );

  decoder_scan #(.N(3), .DWELL(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel_b), .load(load),
    .d(d_b), .idx(idx_b), .wrap(wrap_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: age = cycles the current scan index has been on display; step once it reaches DWELL.
  int  msize[2] = '{4, 8};
  int  mdw[2]   = '{3, 1};
  int  m_idx[2];
  int  m_d[2];
  int  m_wrap[2];
  int  m_age[2];
  bit  m_scan[2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_idx[k] = 0; m_d[k] = 0; m_wrap[k] = 0; m_age[k] = 0; m_scan[k] = 0;
    end
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        int s;
        s = (k == 0) ? int'(sel_a) : int'(sel_b);
        m_wrap[k] = 0;
        if (!rst_n) begin
          m_idx[k] = 0; m_d[k] = 0; m_age[k] = 0; m_scan[k] = 0;
        end else if (!en) begin
          m_d[k] = 0; m_scan[k] = 0;
        end else if (!mode) begin
          m_idx[k] = s; m_d[k] = 1 << s; m_scan[k] = 0;
        end else begin
          if (!m_scan[k] || load) begin
            m_idx[k] = load ? s : 0;
            m_age[k] = 1;
          end else if (m_age[k] >= mdw[k]) begin
            m_wrap[k] = (m_idx[k] == msize[k] - 1) ? 1 : 0;
            m_idx[k]  = (m_idx[k] + 1) % msize[k];
            m_age[k]  = 1;
          end else begin
            m_age[k]++;
          end
          m_scan[k] = 1;
          m_d[k]    = 1 << m_idx[k];
        end
      end
      #1;
      chk("model_d_a",    32'(d_a),    32'(m_d[0]));
      chk("model_idx_a",  32'(idx_a),  32'(m_idx[0]));
      chk("model_wrap_a", 32'(wrap_a), 32'(m_wrap[0]));
      chk("model_d_b",    32'(d_b),    32'(m_d[1]));
      chk("model_idx_b",  32'(idx_b),  32'(m_idx[1]));
      chk("model_wrap_b", 32'(wrap_b), 32'(m_wrap[1]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [3:0] exp_dir [4];
  int         wraps;

  initial begin
    exp_dir = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    rst_n = 1'b0; en = 1'b1; mode = 1'b1; load = 1'b0; sel_a = '0; sel_b = '0;
    tick();
    tick();
    chk("rst_d",    32'(d_a),    32'd0);
    chk("rst_idx",  32'(idx_a),  32'd0);
    chk("rst_wrap", 32'(wrap_a), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_d", 32'(d_a), 32'b0001);

    mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sel_a = 2'(i);
      sel_b = 3'(i);
      tick();
      chk("direct_d", 32'(d_a), 32'(exp_dir[i]));
    end

    mode = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      chk("scan_d",    32'(d_a),    32'(1 << (((k - 1) / 3) % 4)));
      chk("scan_wrap", 32'(wrap_a), 32'(k == 13));
    end

    repeat (4) tick();
    chk("pre_load_idx", 32'(idx_a), 32'd1);
    load = 1'b1; sel_a = 2'd3; sel_b = 3'd5;
    tick();
    load = 1'b0;
    chk("load_idx",  32'(idx_a),  32'd3);
    chk("load_d",    32'(d_a),    32'b1000);
    chk("load_wrap", 32'(wrap_a), 32'd0);
    tick();
    tick();
    chk("load_hold_idx", 32'(idx_a), 32'd3);
    tick();
    chk("load_adv_wrap", 32'(wrap_a), 32'd1);
    chk("load_adv_d",    32'(d_a),    32'b0001);

    repeat (6) tick();
    chk("pre_dis_idx", 32'(idx_a), 32'd2);
    en = 1'b0;
    tick();
    chk("dis_d",   32'(d_a),   32'd0);
    chk("dis_idx", 32'(idx_a), 32'd2);
    en = 1'b1;
    tick();
    chk("reen_d",   32'(d_a),   32'b0001);
    chk("reen_idx", 32'(idx_a), 32'd0);
    wraps = int'(wrap_b);
    for (int k = 0; k < 16; k++) begin
      tick();
      if (wrap_b) wraps++;
    end
    chk("dwell1_wraps", 32'(wraps), 32'd2);

    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      en    = ($urandom_range(0, 9) != 0);
      mode  = ($urandom_range(0, 3) != 0);
      load  = ($urandom_range(0, 7) == 0);
      sel_a = 2'($urandom_range(0, 3));
      sel_b = 3'($urandom_range(0, 7));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
